// File: rtl/alu_issue_sched.sv
// Two-port ALU issue scheduler: a small FIFO per reservation station feeding one
// registered issue slot. Define ALU_SCHED_BRANCH_PRIO_EN to give port 1 strict priority.
module alu_issue_sched #(
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_W     = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [DATA_W-1:0]    req_lhs_p0,
  input  logic [DATA_W-1:0]    req_lhs_p1,
  input  logic [DATA_W-1:0]    req_rhs_p0,
  input  logic [DATA_W-1:0]    req_rhs_p1,
  input  logic [4:0]           req_op_p0,
  input  logic [4:0]           req_op_p1,
  input  logic [ROB_WIDTH-1:0] req_rob_p0,
  input  logic [ROB_WIDTH-1:0] req_rob_p1,
  input  logic [DATA_W-1:0]    req_tj_p0,
  input  logic [DATA_W-1:0]    req_tj_p1,
  input  logic [DATA_W-1:0]    req_fj_p0,
  input  logic [DATA_W-1:0]    req_fj_p1,
  output logic                 calc_enable,
  output logic [DATA_W-1:0]    lhs,
  output logic [DATA_W-1:0]    rhs,
  output logic [4:0]           op,
  output logic [ROB_WIDTH-1:0] rob_dep,
  output logic [DATA_W-1:0]    true_jaddr,
  output logic [DATA_W-1:0]    false_jaddr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 * DATA_W + 5 + ROB_WIDTH;
  localparam logic [EW-1:0] OUT_RST = EW'(5'h1f) << (ROB_WIDTH + 2 * DATA_W);

  logic [EW-1:0]        mem_q [2][FIFO_DEPTH];
  logic [1:0][EW-1:0]   wdata;
  logic [1:0][PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0][CW-1:0]   cnt_q, cnt_d;
  logic [1:0]           nonempty, push, pop;
  logic                 grant, issue;
  logic [EW-1:0]        head;
  logic                 calc_enable_q, calc_enable_d;
  logic [EW-1:0]        out_q, out_d;

  assign wdata[0] = {req_lhs_p0, req_rhs_p0, req_op_p0, req_rob_p0, req_tj_p0, req_fj_p0};
  assign wdata[1] = {req_lhs_p1, req_rhs_p1, req_op_p1, req_rob_p1, req_tj_p1, req_fj_p1};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nonempty[i]  = (cnt_q[i] != '0);
      req_ready[i] = rdy_in && (cnt_q[i] < CW'(FIFO_DEPTH)) && !clear;
    end
  end

  assign push = req_valid & req_ready;

`ifdef ALU_SCHED_BRANCH_PRIO_EN
  assign grant = nonempty[1];
`else
  logic last_q, last_d;

  // When both stations have work, alternate away from the previous winner.
  always_comb begin
    if (&nonempty) grant = ~last_q;
    else           grant = nonempty[1];
  end

  assign last_d = issue ? grant : last_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

  assign issue  = rdy_in && !clear && (|nonempty);
  assign pop[0] = issue && !grant;
  assign pop[1] = issue && grant;
  assign head   = mem_q[grant][rptr_q[grant]];

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    for (int i = 0; i < 2; i++) begin
      if (rdy_in && clear) begin
        cnt_d[i]  = '0;
        wptr_d[i] = '0;
        rptr_d[i] = '0;
      end else begin
        if (push[i]) wptr_d[i] = wptr_q[i] + PW'(1);
        if (pop[i])  rptr_d[i] = rptr_q[i] + PW'(1);
        cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Issue register holds its data whenever nothing is granted or rdy_in is low.
  always_comb begin
    calc_enable_d = calc_enable_q;
    out_d         = out_q;
    if (rdy_in) begin
      calc_enable_d = issue;
      if (issue) out_d = head;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q         <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      calc_enable_q <= 1'b0;
      out_q         <= OUT_RST;
    end else begin
      cnt_q         <= cnt_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      calc_enable_q <= calc_enable_d;
      out_q         <= out_d;
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= wdata[i];
    end
  end

  assign calc_enable = calc_enable_q;
  assign {lhs, rhs, op, rob_dep, true_jaddr, false_jaddr} = out_q;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized bench for alu_issue_sched against a queue-based reference model,
// with directed sequences for single issue, contention, clear, stall and reset.
module tb_alu_issue_sched;
  localparam int DEPTH = 2;
  localparam int RW    = 4;

  typedef struct packed {
    logic [31:0]   lhs;
    logic [31:0]   rhs;
    logic [4:0]    op;
    logic [RW-1:0] rob;
    logic [31:0]   tj;
    logic [31:0]   fj;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n, rdy, clr;
  logic [1:0]    vld, req_ready;
  ent_t          in0, in1;
  logic          calc_enable;
  logic [31:0]   lhs, rhs, tj, fj;
  logic [4:0]    op;
  logic [RW-1:0] rob_dep;

  always #5 clk = ~clk;

  alu_issue_sched #(.FIFO_DEPTH(DEPTH), .ROB_WIDTH(RW), .DATA_W(32)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .clear(clr),
    .req_valid(vld), .req_ready(req_ready),
    .req_lhs_p0(in0.lhs), .req_lhs_p1(in1.lhs),
    .req_rhs_p0(in0.rhs), .req_rhs_p1(in1.rhs),
    .req_op_p0(in0.op), .req_op_p1(in1.op),
    .req_rob_p0(in0.rob), .req_rob_p1(in1.rob),
    .req_tj_p0(in0.tj), .req_tj_p1(in1.tj),
    .req_fj_p0(in0.fj), .req_fj_p1(in1.fj),
    .calc_enable(calc_enable), .lhs(lhs), .rhs(rhs), .op(op),
    .rob_dep(rob_dep), .true_jaddr(tj), .false_jaddr(fj)
  );

  ent_t q0[$], q1[$];
  ent_t mout;
  logic men;
  logic mlast;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t r;
    r.lhs = $urandom;
    r.rhs = $urandom;
    r.op  = 5'($urandom);
    r.rob = RW'($urandom);
    r.tj  = $urandom;
    r.fj  = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mlast   = 1'b1;
    men     = 1'b0;
    mout    = '0;
    mout.op = 5'h1f;
  endtask

  // Inputs must already be driven; checks ready, steps one edge, checks outputs.
  task automatic cycle(input string tag);
    int s0, s1, g;
    logic [1:0] er;
    #1;
    s0 = q0.size();
    s1 = q1.size();
    er[0] = rdy && (s0 < DEPTH) && !clr;
    er[1] = rdy && (s1 < DEPTH) && !clr;
    check({tag, "_rdy"}, req_ready, er);
    if (rdy) begin
      if (clr) begin
        q0.delete();
        q1.delete();
        men = 1'b0;
      end else begin
        if (s0 > 0 || s1 > 0) begin
`ifdef ALU_SCHED_BRANCH_PRIO_EN
          g = (s1 > 0) ? 1 : 0;
`else
          if (s0 > 0 && s1 > 0) g = mlast ? 0 : 1;
          else                  g = (s1 > 0) ? 1 : 0;
          mlast = (g == 1);
`endif
          if (g == 1) mout = q1.pop_front();
          else        mout = q0.pop_front();
          men = 1'b1;
        end else begin
          men = 1'b0;
        end
        if (vld[0] && er[0]) q0.push_back(in0);
        if (vld[1] && er[1]) q1.push_back(in1);
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_en"}, calc_enable, men);
    check({tag, "_data"}, {lhs, rhs, op, rob_dep, tj, fj}, mout);
  endtask

  task automatic fill(input string tag, input int n);
    vld = 2'b11;
    for (int i = 0; i < n; i++) begin
      in0 = rnd_ent();
      in1 = rnd_ent();
      cycle(tag);
    end
    vld = 2'b00;
  endtask

  initial begin
    rst_n = 1'b1;
    rdy   = 1'b1;
    clr   = 1'b0;
    vld   = 2'b00;
    in0   = rnd_ent();
    in1   = rnd_ent();
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("reset_en", calc_enable, 1'b0);
    check("reset_data", {lhs, rhs, op, rob_dep, tj, fj}, mout);
    check("reset_rdy", req_ready, 2'b11);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single arithmetic request into an idle block.
    in0 = rnd_ent();
    in0.lhs = 32'd5;
    in0.rhs = 32'd7;
    in0.op  = 5'd0;
    in0.rob = RW'(3);
    vld = 2'b01;
    cycle("single_push");
    vld = 2'b00;
    cycle("single_issue");
    check("single_en", calc_enable, 1'b1);
    check("single_lhs", lhs, 32'd5);
    check("single_rhs", rhs, 32'd7);
    check("single_rob", rob_dep, RW'(3));
    cycle("single_idle");
    check("single_once", calc_enable, 1'b0);

    // Both ports streaming: alternation, back-pressure and pointer wrap.
    fill("both", 10);
    for (int i = 0; i < 6; i++) cycle("drain");

    // Flush with buffered entries and a same-edge push.
    fill("pre_clr", 4);
    clr = 1'b1;
    vld = 2'b11;
    in0 = rnd_ent();
    in1 = rnd_ent();
    cycle("clr");
    check("clr_en", calc_enable, 1'b0);
    clr = 1'b0;
    vld = 2'b00;
    for (int i = 0; i < 4; i++) cycle("post_clr");

    // Stall with pending entries.
    fill("pre_stall", 4);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 2'($urandom);
      in0 = rnd_ent();
      in1 = rnd_ent();
      cycle("stall");
    end
    rdy = 1'b1;
    vld = 2'b00;
    for (int i = 0; i < 6; i++) cycle("resume");

    // Asynchronous reset between edges with full FIFOs.
    fill("pre_rst", 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", calc_enable, 1'b0);
    check("arst_op", op, 5'h1f);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cycle("post_rst");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 19) == 0);
      vld = 2'($urandom);
      in0 = rnd_ent();
      in1 = rnd_ent();
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
